// File: rtl/dog_img.sv
// dog_img: Difference-of-Gaussians stage for the SIFT pipeline.
// Streams two same-octave blurred images (A = lower sigma, B = higher sigma)
// out of BRAM in lockstep and writes the signed difference A-B, one pixel per
// clock, into the DoG BRAM.  Start/done and external-BRAM ports match the
// blur stage.
// Optional feature macro: DOG_STATS_EN adds max_abs_out / max_abs_addr_out,
// the largest |A-B| of the pass and the first address where it occurred.
module dog_img #(
  parameter int BIT_DEPTH    = 8,
  parameter int WIDTH        = 64,
  parameter int HEIGHT       = 64,
  parameter int READ_LATENCY = 2,
  localparam int AW          = $clog2(WIDTH * HEIGHT)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  output logic [AW-1:0]        ext_read_addr,
  output logic                 ext_read_addr_valid,
  input  logic [BIT_DEPTH-1:0] ext_pixel_a_in,
  input  logic [BIT_DEPTH-1:0] ext_pixel_b_in,
  output logic [AW-1:0]        ext_write_addr,
  output logic                 ext_write_valid,
  output logic [BIT_DEPTH:0]   ext_pixel_out,
  output logic                 busy_out,
  output logic                 dog_done
`ifdef DOG_STATS_EN
  ,
  output logic [BIT_DEPTH-1:0] max_abs_out,
  output logic [AW-1:0]        max_abs_addr_out
`endif
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t          state, state_next;
  logic [AW-1:0]   read_addr_next;
  logic            read_valid_next;
  logic            busy_next;
  logic            done_next;
  logic            start_accept;

  // Read-side pipeline: address/valid delayed to line up with BRAM data.
  logic [READ_LATENCY-1:0] vld_sr;
  logic [AW-1:0]           addr_sr [READ_LATENCY];

  // Zero-extended subtraction; range is +/-(2^BIT_DEPTH-1), so it cannot overflow.
  logic [BIT_DEPTH:0] diff;
  assign diff = {1'b0, ext_pixel_a_in} - {1'b0, ext_pixel_b_in};

  // A start is only honoured from IDLE; while busy it is ignored.
  assign start_accept = (state == IDLE) && start_in;

  // Next-state and next control-output logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next      = state;
    read_addr_next  = ext_read_addr;
    read_valid_next = ext_read_addr_valid;
    busy_next       = busy_out;
    done_next       = dog_done;
    unique case (state)
      IDLE: begin
        if (start_in) begin
          state_next      = READ;
          read_addr_next  = '0;
          read_valid_next = 1'b1;
          busy_next       = 1'b1;
          done_next       = 1'b0;
        end
      end
      READ: begin
        // The counter parks on the last address rather than wrapping.
        if (ext_read_addr == LAST_ADDR) begin
          read_valid_next = 1'b0;
          state_next      = DRAIN;
        end else begin
          read_addr_next = ext_read_addr + AW'(1);
        end
      end
      DRAIN: begin
        // Pipeline empty while the final write is on the port: done next cycle.
        if (!(|vld_sr) && ext_write_valid) begin
          state_next = DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and registered control outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state               <= IDLE;
      ext_read_addr       <= '0;
      ext_read_addr_valid <= 1'b0;
      busy_out            <= 1'b0;
      dog_done            <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state               <= state_next;
      ext_read_addr       <= read_addr_next;
      ext_read_addr_valid <= read_valid_next;
      busy_out            <= busy_next;
      dog_done            <= done_next;
    end
  end

  // Delay address/valid by the BRAM read latency.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      // NOTE: the address pipe is a handful of flops, not a RAM, so it is
      // cleared along with the valid bits; clearing valids alone is what
      // guarantees no write escapes after a mid-pass reset.
      vld_sr <= '0;
      for (int i = 0; i < READ_LATENCY; i++) addr_sr[i] <= '0;
    end else begin
      vld_sr[0]  <= ext_read_addr_valid;
      addr_sr[0] <= ext_read_addr;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        addr_sr[i] <= addr_sr[i-1];
      end
    end
  end

  // Write stage: register the difference when BRAM data is valid.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ext_write_valid <= 1'b0;
      ext_write_addr  <= '0;
      ext_pixel_out   <= '0;
    end else begin
      ext_write_valid <= vld_sr[READ_LATENCY-1];
      if (vld_sr[READ_LATENCY-1]) begin
        ext_write_addr <= addr_sr[READ_LATENCY-1];
        ext_pixel_out  <= diff;
      end
    end
  end

`ifdef DOG_STATS_EN
  // |A-B| fits in BIT_DEPTH bits: subtract the smaller from the larger.
  logic [BIT_DEPTH-1:0] abs_diff;
  assign abs_diff = diff[BIT_DEPTH] ? (ext_pixel_b_in - ext_pixel_a_in)
                                    : (ext_pixel_a_in - ext_pixel_b_in);

  // Track the largest |A-B|; strict compare keeps the first address on ties.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      max_abs_out      <= '0;
      max_abs_addr_out <= '0;
    end else if (start_accept) begin
      max_abs_out      <= '0;
      max_abs_addr_out <= '0;
    end else if (vld_sr[READ_LATENCY-1] && (abs_diff > max_abs_out)) begin
      max_abs_out      <= abs_diff;
      max_abs_addr_out <= addr_sr[READ_LATENCY-1];
    end
  end
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_dog_img.sv
// tb_dog_img: scoreboard bench for dog_img with a latency-2 BRAM model.
// Every valid read pushes the expected write (address, A-B, cycle) and the
// monitor pops and compares when the DUT writes.
module tb_dog_img;

  localparam int N    = 64 * 64;
  localparam int AW   = 12;
  localparam int PASS = N + 2 + 2;  // start_in to dog_done, READ_LATENCY = 2

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          start_in = 1'b0;
  logic [AW-1:0] ext_read_addr;
  logic          ext_read_addr_valid;
  logic [7:0]    ext_pixel_a_in;
  logic [7:0]    ext_pixel_b_in;
  logic [AW-1:0] ext_write_addr;
  logic          ext_write_valid;
  logic [8:0]    ext_pixel_out;
  logic          busy_out;
  logic          dog_done;
`ifdef DOG_STATS_EN
  logic [7:0]    max_abs_out;
  logic [AW-1:0] max_abs_addr_out;
`endif

  dog_img dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .start_in            (start_in),
    .ext_read_addr       (ext_read_addr),
    .ext_read_addr_valid (ext_read_addr_valid),
    .ext_pixel_a_in      (ext_pixel_a_in),
    .ext_pixel_b_in      (ext_pixel_b_in),
    .ext_write_addr      (ext_write_addr),
    .ext_write_valid     (ext_write_valid),
    .ext_pixel_out       (ext_pixel_out),
    .busy_out            (busy_out),
    .dog_done            (dog_done)
`ifdef DOG_STATS_EN
    ,
    .max_abs_out         (max_abs_out),
    .max_abs_addr_out    (max_abs_addr_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Blurred-image BRAMs with two-cycle read latency.
  logic [7:0] mem_a [N];
  logic [7:0] mem_b [N];
  logic [7:0] a_s1, a_s2, b_s1, b_s2;
  always @(posedge clk_in) begin
    a_s1 <= mem_a[ext_read_addr];
    b_s1 <= mem_b[ext_read_addr];
    a_s2 <= a_s1;
    b_s2 <= b_s1;
  end
  assign ext_pixel_a_in = a_s2;
  assign ext_pixel_b_in = b_s2;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [8:0]    data;
    int            cyc;
  } exp_t;

  exp_t       sb [$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         exp_raddr = 0;
  int         writes_seen = 0;
  int         done_rises = 0;
  logic       prev_done = 1'b0;
  logic [8:0] last_wdata;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk_in) begin
    if (ext_read_addr_valid) begin
      exp_t e;
      int   d;
      n_tests++;
      if (int'(ext_read_addr) !== exp_raddr) begin
        n_fail++;
        $display("FAIL read_addr: got %0d expected %0d", ext_read_addr, exp_raddr);
      end
      d      = int'(mem_a[exp_raddr]) - int'(mem_b[exp_raddr]);
      e.addr = AW'(exp_raddr);
      e.data = 9'(d);
      e.cyc  = cyc + 3;
      sb.push_back(e);
      exp_raddr++;
    end
    if (ext_write_valid) begin
      n_tests++;
      writes_seen++;
      last_wdata = ext_pixel_out;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected", ext_write_addr, ext_pixel_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (ext_write_addr !== e.addr || ext_pixel_out !== e.data || cyc !== e.cyc) begin
          n_fail++;
          $display("FAIL write: addr %0d data %h cycle %0d, expected addr %0d data %h cycle %0d",
                   ext_write_addr, ext_pixel_out, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
    if (dog_done && !prev_done) done_rises++;
    prev_done = dog_done;
  end

  task automatic fill(input int mode, input logic [7:0] ca, input logic [7:0] cb);
    for (int i = 0; i < N; i++) begin
      mem_a[i] = (mode == 1) ? 8'(i) : ca;
      mem_b[i] = cb;
    end
  endtask

  // Start a pass and wait for dog_done; optionally re-pulse start mid-pass.
  task automatic run_pass(input string name, input int restart_at);
    int   t0;
    int   elapsed;
    logic seen_done;
    logic pulsed;
    exp_raddr   = 0;
    writes_seen = 0;
    done_rises  = 0;
    seen_done   = 1'b0;
    pulsed      = 1'b0;
    @(posedge clk_in);
    #1 start_in = 1'b1;
    t0 = cyc;
    elapsed = 0;
    for (int k = 1; k <= 3 * N; k++) begin
      @(posedge clk_in);
      #1 start_in = 1'b0;
      if (restart_at >= 0 && !pulsed && ext_read_addr_valid &&
          int'(ext_read_addr) == restart_at) begin
        start_in = 1'b1;
        pulsed   = 1'b1;
      end
      if (dog_done) begin
        seen_done = 1'b1;
        elapsed   = cyc - t0;
        break;
      end
    end
    start_in = 1'b0;
    n_tests++;
    if (!seen_done) begin
      n_fail++;
      $display("FAIL %s timeout: dog_done not seen within %0d cycles", name, 3 * N);
    end else if (elapsed !== PASS) begin
      n_fail++;
      $display("FAIL %s latency: dog_done after %0d cycles, expected %0d", name, elapsed, PASS);
    end
    repeat (3) @(posedge clk_in);
    #1;
    n_tests++;
    if (writes_seen !== N || sb.size() !== 0) begin
      n_fail++;
      $display("FAIL %s writes: %0d writes, %0d pending, expected %0d and 0",
               name, writes_seen, sb.size(), N);
    end
    n_tests++;
    if (dog_done !== 1'b1 || busy_out !== 1'b0 || done_rises !== 1) begin
      n_fail++;
      $display("FAIL %s done_hold: done %b busy %b rises %0d, expected 1 0 1",
               name, dog_done, busy_out, done_rises);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    n_tests++;
    if ({ext_read_addr_valid, ext_write_valid, busy_out, dog_done} !== 4'b0000 ||
        ext_read_addr !== '0 || ext_write_addr !== '0 || ext_pixel_out !== '0) begin
      n_fail++;
      $display("FAIL reset: rv %b wv %b busy %b done %b raddr %0d waddr %0d pix %h, expected all 0",
               ext_read_addr_valid, ext_write_valid, busy_out, dog_done,
               ext_read_addr, ext_write_addr, ext_pixel_out);
    end
    rst_in = 1'b1;
  endtask

  task automatic test_equal();
    fill(0, 8'h80, 8'h80);
    run_pass("equal", -1);
    n_tests++;
    if (last_wdata !== 9'h000) begin
      n_fail++;
      $display("FAIL equal_value: got %h expected 000", last_wdata);
    end
  endtask

  task automatic test_const();
    fill(0, 8'd200, 8'd50);
    run_pass("a200_b50", -1);
    n_tests++;
    if (last_wdata !== 9'd150) begin
      n_fail++;
      $display("FAIL a200_b50_value: got %h expected 096", last_wdata);
    end
    fill(0, 8'd0, 8'd255);
    run_pass("a0_b255", -1);
    n_tests++;
    if (last_wdata !== 9'h101) begin
      n_fail++;
      $display("FAIL a0_b255_value: got %h expected 101", last_wdata);
    end
  endtask

  task automatic test_ramp();
    fill(1, 8'd0, 8'd0);
    run_pass("ramp", -1);
    n_tests++;
    if (last_wdata !== 9'h0ff) begin
      n_fail++;
      $display("FAIL ramp_last: got %h expected 0ff", last_wdata);
    end
  endtask

  task automatic test_restart_ignored();
    fill(1, 8'd0, 8'd3);
    run_pass("restart", 1000);
  endtask

  task automatic test_reset_mid();
    logic hit;
    fill(0, 8'd9, 8'd4);
    exp_raddr = 0;
    hit = 1'b0;
    @(posedge clk_in);
    #1 start_in = 1'b1;
    for (int k = 0; k < 2 * N; k++) begin
      @(posedge clk_in);
      #1 start_in = 1'b0;
      if (ext_read_addr_valid && ext_read_addr == AW'(1000)) begin
        hit = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL mid_reset_reach: read address 1000 never presented");
    end
    rst_in = 1'b0;
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    sb.delete();
    n_tests++;
    if (ext_write_valid !== 1'b0 || busy_out !== 1'b0 || dog_done !== 1'b0 ||
        ext_read_addr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: wv %b busy %b done %b rv %b, expected 0 0 0 0",
               ext_write_valid, busy_out, dog_done, ext_read_addr_valid);
    end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_in);
      #1;
      n_tests++;
      if (ext_write_valid || ext_read_addr_valid) begin
        n_fail++;
        $display("FAIL mid_reset_quiet: cycle %0d wv %b rv %b, expected 0 0",
                 k, ext_write_valid, ext_read_addr_valid);
      end
    end
    run_pass("after_reset", -1);
  endtask

`ifdef DOG_STATS_EN
  task automatic test_stats();
    fill(0, 8'd10, 8'd10);
    mem_a[777] = 8'd250;
    mem_a[900] = 8'd250;
    run_pass("stats", -1);
    n_tests++;
    if (max_abs_out !== 8'd240 || max_abs_addr_out !== AW'(777)) begin
      n_fail++;
      $display("FAIL stats: max %0d addr %0d, expected 240 777", max_abs_out, max_abs_addr_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_equal();
    test_const();
    test_ramp();
    test_restart_ignored();
    test_reset_mid();
`ifdef DOG_STATS_EN
    test_stats();
`endif
    repeat (2) @(posedge clk_in);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
